imem_loader: RTL and testbench
==============================

# imem_loader

Hardware program loader for the RISC-V core's instruction memory. It takes a byte stream (length header, then little-endian instruction words), assembles each 32-bit word, and writes it into the instruction memory through a write port. It holds the core in reset until the last word is committed. In the system it replaces the simulation-only `$readmemb` fill of `imem1.tab_inst`, so the same bench program can be booted over a byte link.

## Interface
Parameters:
- `PROG_SIZE`, 648: instruction memory depth in 32-bit words; maximum loadable length.
- `AW`, `$clog2(PROG_SIZE)`: word-address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured in IDLE, DONE, ERR.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  AW  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `core_rst`  out  1  reset to the `riscv` core; high while no valid program is resident.
- `done`  out  1  load completed successfully.
- `err`  out  1  header length exceeded `PROG_SIZE`.

## Operation
- States: IDLE, HDR_LO, HDR_HI, LOAD, DONE, ERR.
- IDLE: `start` → HDR_LO.
- HDR_LO: a transfer latches `len[7:0]` → HDR_HI.
- HDR_HI: a transfer latches `len[15:8]`, then branches:
  - `len == 0` → DONE.
  - `len > PROG_SIZE` → ERR.
  - otherwise → LOAD, with word index 0 and byte index 0.
- LOAD: byte k (0..3) of a word goes to bits `[8k+7:8k]`. On the 4th byte:
  - the word is registered to `imem_wdata` and the word index to `imem_addr`;
  - byte index wraps to 0 and the word index increments.
  - On the 4th byte of word `len-1` → DONE.
- DONE or ERR: `start` → HDR_LO; `core_rst` is reasserted and `len` and both indices are cleared.
- `start` is ignored in HDR_LO, HDR_HI and LOAD.
- `byte_ready` = 1 in HDR_LO, HDR_HI and LOAD; 0 otherwise. Bytes offered in IDLE, DONE or ERR are not consumed.
- `len` is 16 bits. The comparison against `PROG_SIZE` is unsigned. Word index is `AW` bits and never exceeds `len-1`, so no wrap is possible.
- Reset value of every output:
  - `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=1, `done`=0, `err`=0.
  - State = IDLE.
- `rst` during any state returns to IDLE with the outputs above. A partial word is discarded. Words already written stay in memory but are considered invalid, since `core_rst`=1.

## Timing
- `imem_we` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `imem_addr`/`imem_wdata` are valid in that same cycle.
- Peak throughput: one byte per cycle, so one write per 4 cycles. Back-to-back transfers need no bubbles.
- `byte_valid` gaps stall assembly without side effects.
- `done`=1 and `core_rst`=0 from the cycle after the final `imem_we` pulse. Memory therefore holds the last word before the core leaves reset.
- `len == 0`: `done`=1 and `core_rst`=0 in the cycle after the HDR_HI transfer.
- `err`=1 in the cycle after the HDR_HI transfer. `core_rst` stays 1.
- `start` in DONE/ERR:
  - next cycle: `done`=0, `err`=0, `core_rst`=1, `byte_ready`=1.
- `start` coinciding with `rst`: reset wins.

## Structure
- Package `loader_pkg`:
  - `loader_state_t` enum (6 states);
  - `HDR_BYTES`=2;
  - `BYTES_PER_WORD`=4.
- One sub-module, `byte_packer`:
  - 2-bit byte counter plus 32-bit shift/assembly register;
  - `clear`, `push` and `word_valid` signals.
- The top level holds the FSM, the length register, the word index and the output registers.

## Test plan
- Stream `02 00 13 05 A0 00 93 05 B0 00`, `byte_valid` held high → two writes: addr 0 = 0x00A00513, addr 1 = 0x00B00593; `done`=1 and `core_rst`=0 one cycle after the second `imem_we`.
- Header `00 00` → no `imem_we`; `done`=1 and `core_rst`=0 the cycle after the header; `byte_ready`=0.
- Header `89 02` (649 > 648) → `err`=1, no write, `core_rst`=1, `byte_ready`=0; following bytes are not consumed.
- Same stream as the first scenario with `byte_valid` low on alternate cycles → identical writes, each `imem_we` a single cycle.
- Header `01 00`, then 2 data bytes, then `rst` for 1 cycle → IDLE, no write, `core_rst`=1. A subsequent `start` and full load of `01 00 EF BE AD DE` writes addr 0 = 0xDEADBEEF.
- `start` in DONE, then header `01 00` and 4 bytes `78 56 34 12` → `core_rst`=1 the next cycle; addr 0 = 0x12345678; `done`=1 again.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_LOAD,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int AW = 10
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid fires with the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);
    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] cnt;
    logic [23:0]   sh;

    // Bytes enter at the top and shift down, so after three pushes byte 0 sits in [7:0].
    assign word_valid = push && (cnt == CW'(BYTES_PER_WORD - 1));
    assign word       = {data, sh};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
            sh  <= '0;
        end else if (push) begin
            cnt <= cnt + 1'b1;
            sh  <= {data, sh[23:8]};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core in reset until done.
module imem_loader
    import loader_pkg::*;
#(
    parameter int PROG_SIZE = 648,
    parameter int AW        = $clog2(PROG_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_rst,
    output logic          done,
    output logic          err
);
    loader_state_t state, state_n;
    logic [15:0]   len;
    logic [15:0]   len_full;
    logic [AW-1:0] widx;
    logic          xfer, push, clear, last;
    logic          word_valid;
    logic [31:0]   word;

    assign bus.byte_ready = (state == S_HDR_LO) || (state == S_HDR_HI) || (state == S_LOAD);
    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign push     = xfer && (state == S_LOAD);
    assign clear    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign len_full = {bus.byte_data, len[7:0]};
    assign last     = (16'(widx) == len - 16'd1);

    // The final word is written in the first DONE cycle; completion shows one cycle later.
    assign done     = (state == S_DONE) && !bus.imem_we;
    assign core_rst = !done;
    assign err      = (state == S_ERR);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (push),
        .data       (bus.byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_HDR_LO;
            S_HDR_LO: if (xfer)  state_n = S_HDR_HI;
            S_HDR_HI: if (xfer) begin
                if (len_full == 16'd0)                 state_n = S_DONE;
                else if (len_full > 16'(PROG_SIZE))    state_n = S_ERR;
                else                                   state_n = S_LOAD;
            end
            S_LOAD:   if (word_valid && last) state_n = S_DONE;
            S_DONE,
            S_ERR:    if (start) state_n = S_HDR_LO;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            len            <= '0;
            widx           <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            state       <= state_n;
            bus.imem_we <= word_valid;
            if (clear) begin
                len  <= '0;
                widx <= '0;
            end
            if (xfer && state == S_HDR_LO) len[7:0]  <= bus.byte_data;
            if (xfer && state == S_HDR_HI) len[15:8] <= bus.byte_data;
            if (word_valid) begin
                bus.imem_addr  <= widx;
                bus.imem_wdata <= word;
                if (!last) widx <= widx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load scenarios checked against a stream-level reference model.
module tb_imem_loader;
    localparam int PS = 648;
    localparam int AW = $clog2(PS);

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic core_rst, done, err;

    imem_loader_if #(.AW(AW)) bus();

    imem_loader #(.PROG_SIZE(PS), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.slave),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int   total = 0, passed = 0;
    int   cyc = 0, last_we = -1, done_rise = -1, dbl = 0;
    logic we_q = 1'b0, done_q = 1'b0;
    wr_t  got[$];
    wr_t  exp_q[$];
    logic e_done, e_err;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (bus.imem_we) begin
            w.addr = int'(bus.imem_addr);
            w.data = bus.imem_wdata;
            got.push_back(w);
            last_we = cyc;
            if (we_q) dbl++;
        end
        we_q = bus.imem_we;
        if (done && !done_q) done_rise = cyc;
        done_q = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        bus.byte_valid = 1'b0;
        tick(gap);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        while (!bus.byte_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.byte_ready) begin
            total++;
            $error("FAIL send_timeout: byte_ready observed 0 expected 1");
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    // Reference: header gives word count; word i is bytes 2+4i..2+4i+3, little-endian.
    task automatic model(input bq_t bs);
        int  len;
        wr_t w;
        len = int'(bs[0]) | (int'(bs[1]) << 8);
        exp_q.delete();
        e_err  = (len > PS);
        e_done = !e_err;
        if (!e_err)
            for (int i = 0; i < len; i++) begin
                w.addr = i;
                w.data = {bs[2+4*i+3], bs[2+4*i+2], bs[2+4*i+1], bs[2+4*i]};
                exp_q.push_back(w);
            end
    endtask

    task automatic run(input bq_t bs, input int gap, input string tag);
        int t_end;
        model(bs);
        got.delete();
        done_rise = -1;
        last_we   = -1;
        pulse_start();
        chk({tag, " start_ready"}, bus.byte_ready, 1'b1);
        chk({tag, " start_done"},  done,           1'b0);
        chk({tag, " start_err"},   err,            1'b0);
        chk({tag, " start_crst"},  core_rst,       1'b1);
        foreach (bs[i])
            if (i < 2 || !e_err)
                send(bs[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        t_end = cyc;
        tick(4);
        chk({tag, " nwr"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s addr%0d", tag, i), got[i].addr, exp_q[i].addr);
            chk($sformatf("%s data%0d", tag, i), got[i].data, exp_q[i].data);
        end
        chk({tag, " done"},  done,           e_done);
        chk({tag, " err"},   err,            e_err);
        chk({tag, " crst"},  core_rst,       !e_done);
        chk({tag, " ready"}, bus.byte_ready, 1'b0);
        if (e_done) begin
            chk({tag, " done_cycle"}, done_rise, t_end + ((exp_q.size() > 0) ? 2 : 1));
            if (exp_q.size() > 0) chk({tag, " done_after_we"}, done_rise - last_we, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        bq_t         q;
        logic [15:0] L;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        tick(3);
        chk("rst ready", bus.byte_ready, 1'b0);
        chk("rst we",    bus.imem_we,    1'b0);
        chk("rst addr",  bus.imem_addr,  '0);
        chk("rst wdata", bus.imem_wdata, 32'h0);
        chk("rst crst",  core_rst,       1'b1);
        chk("rst done",  done,           1'b0);
        chk("rst err",   err,            1'b0);
        rst = 1'b0;
        tick(2);

        q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        run(q, 0, "b2b");
        if (got.size() == 2) begin
            chk("b2b word0", got[0].data, 32'h00A00513);
            chk("b2b word1", got[1].data, 32'h00B00593);
        end
        run(q, 1, "alt");

        q = '{8'h00, 8'h00};
        run(q, 0, "len0");

        q = '{8'h89, 8'h02};
        run(q, 0, "over");
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        tick(3);
        chk("over ignore_ready", bus.byte_ready, 1'b0);
        chk("over ignore_nwr",   got.size(),     0);
        chk("over ignore_err",   err,            1'b1);
        bus.byte_valid = 1'b0;

        // Reset in the middle of a word discards it.
        got.delete();
        pulse_start();
        send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("midrst nwr",   got.size(),     0);
        chk("midrst crst",  core_rst,       1'b1);
        chk("midrst done",  done,           1'b0);
        chk("midrst ready", bus.byte_ready, 1'b0);
        q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run(q, 0, "reload");
        if (got.size() == 1) chk("reload word", got[0].data, 32'hDEADBEEF);

        q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run(q, 0, "restart");
        if (got.size() == 1) chk("restart word", got[0].data, 32'h12345678);

        for (int it = 0; it < 6; it++) begin
            L = 16'($urandom_range(1, 8));
            q.delete();
            q.push_back(L[7:0]);
            q.push_back(L[15:8]);
            repeat (4 * int'(L)) q.push_back(8'($urandom));
            run(q, -1, $sformatf("rnd%0d", it));
        end

        L = 16'(PS);
        q.delete();
        q.push_back(L[7:0]);
        q.push_back(L[15:8]);
        repeat (4 * PS) q.push_back(8'($urandom));
        run(q, 0, "max");

        chk("we_single", dbl, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
